// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl
//   Sequencer for a Simon Says game. Each round it appends one pseudo-random arrow
//   to the sequence and plays the whole sequence on the display. It then checks the
//   player's key presses against the sequence.
//   Arrow codes: 000 LEFT, 001 DOWN, 010 UP, 011 RIGHT, 111 NOTHING.
//   A dir_in code in 100..110 is treated as "no key".
//
// Ports
//   clk        in   1  system clock, rising edge
//   resetn     in   1  asynchronous active-low reset
//   start      in   1  1-cycle pulse; starts a new game from IDLE/WIN/LOSE
//   dir_in     in   3  decoded arrow from the key decoder (111 = no key)
//   arrow_out  out  3  arrow to display; 111 when blank
//   show_phase out  1  1 while the sequence is playing (player input ignored)
//   level      out  7  current sequence length (0 in IDLE)
//   win        out  1  high in WIN until the next start
//   game_over  out  1  high in LOSE until the next start
//   dbg_state  out  3  current FSM state, for observation only
//
// Handshake: none. start is a single-cycle pulse and is sampled only in IDLE, WIN
// or LOSE. dir_in is a level: one press is the span from a valid arrow code back to
// "no key". Holding a key therefore produces exactly one entry.
//
// Configuration
//   SIMON_TIMEOUT_EN defined   : WAIT_PRESS loses after TIMEOUT_CYCLES without a press.
//   SIMON_TIMEOUT_EN undefined : WAIT_PRESS waits forever.
module simon_game_ctrl #(
  parameter int          MAX_LEN        = 16,
  parameter int          SHOW_CYCLES    = 25_000_000,
  parameter int          GAP_CYCLES     = 12_500_000,
  parameter int          TIMEOUT_CYCLES = 250_000_000,
  parameter logic [7:0]  SEED           = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] dir_in,
  output logic [2:0] arrow_out,
  output logic       show_phase,
  output logic [6:0] level,
  output logic       win,
  output logic       game_over,
  output logic [2:0] dbg_state
);

  localparam int IW = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SHOW, S_GAP, S_WAIT_PRESS, S_WAIT_RELEASE, S_WIN, S_LOSE
  } state_t;

  state_t        state, state_next;
  logic [7:0]    lfsr;
  logic [IW-1:0] idx;
  logic [31:0]   timer;
  logic [1:0]    seq_buf [MAX_LEN];

  logic          pressed;
  logic          more;
  logic          show_done;
  logic          gap_done;

  assign pressed   = ~dir_in[2];
  // Another entry of the current sequence follows the one at idx.
  assign more      = (7'(idx) + 7'd1) < level;
  assign show_done = (timer == 32'(SHOW_CYCLES - 1));
  assign gap_done  = (timer == 32'(GAP_CYCLES - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_WIN, S_LOSE: if (start) state_next = S_ADD;
      S_ADD:                 state_next = S_SHOW;
      S_SHOW:                if (show_done) state_next = S_GAP;
      S_GAP:                 if (gap_done) state_next = more ? S_SHOW : S_WAIT_PRESS;
      S_WAIT_PRESS: begin
        if (pressed) begin
          state_next = (dir_in[1:0] == seq_buf[idx]) ? S_WAIT_RELEASE : S_LOSE;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
          state_next = S_LOSE;
        end
`endif
      end
      S_WAIT_RELEASE: begin
        if (!pressed) begin
          if (more)                          state_next = S_WAIT_PRESS;
          else if (level == 7'(MAX_LEN))     state_next = S_WIN;
          else                               state_next = S_ADD;
        end
      end
      default:               state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      lfsr  <= SEED;
      level <= '0;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_next;
      // Fibonacci LFSR, taps 8,6,5,4; free-running so the arrow depends on timing.
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      // Every state entry restarts the timer, so SHOW/GAP last exactly N cycles.
      timer <= (state_next != state) ? '0 : timer + 32'd1;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            level <= '0;
            idx   <= '0;
          end
        end
        S_ADD: begin
          level <= level + 7'd1;
          idx   <= '0;
        end
        S_GAP: begin
          if (gap_done) idx <= more ? idx + IW'(1) : '0;
        end
        S_WAIT_RELEASE: begin
          if (!pressed && more) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Sequence storage needs no reset: entries are always written before being read.
  always_ff @(posedge clk) begin
    if (state == S_ADD) seq_buf[level[IW-1:0]] <= lfsr[1:0];
  end

  always_comb begin
    arrow_out  = 3'b111;
    show_phase = 1'b0;
    win        = 1'b0;
    game_over  = 1'b0;
    case (state)
      S_SHOW: begin
        arrow_out  = {1'b0, seq_buf[idx]};
        show_phase = 1'b1;
      end
      S_GAP:          show_phase = 1'b1;
      S_WAIT_PRESS,
      S_WAIT_RELEASE: if (pressed) arrow_out = dir_in;
      S_WIN:          win = 1'b1;
      S_LOSE:         game_over = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// tb_simon_game_ctrl
//   Randomized bench for simon_game_ctrl (MAX_LEN=3, SHOW=4, GAP=2, TIMEOUT=20).
//   A game-level model tracks the round, the play offset and the player position.
//   It derives the expected outputs for every cycle. A set of literal checks pins
//   the model to known values.
`timescale 1ns/1ps
module tb_simon_game_ctrl;

  localparam int         MAX_LEN = 3;
  localparam int         SHOW    = 4;
  localparam int         GAP     = 2;
  localparam int         TMO     = 20;
  localparam logic [7:0] SEED    = 8'hA5;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [2:0] dir_in;
  logic [2:0] arrow_out;
  logic       show_phase;
  logic [6:0] level;
  logic       win;
  logic       game_over;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  simon_game_ctrl #(
    .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO), .SEED(SEED)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .dir_in(dir_in),
    .arrow_out(arrow_out), .show_phase(show_phase), .level(level),
    .win(win), .game_over(game_over), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_PLAY, M_INPUT, M_WIN, M_LOSE} mmode_t;
  mmode_t     m_mode = M_IDLE;
  logic [7:0] m_lfsr = SEED;
  logic [1:0] exp_q[$];          // the arrow sequence of the current game
  int         m_len  = 0;        // sequence length of the current round
  int         m_t    = 0;        // cycles elapsed in the current play-out
  int         m_pos  = 0;        // player position in the sequence
  int         m_wait = 0;        // idle cycles spent waiting for a press
  bit         m_held = 1'b0;     // current entry accepted, waiting for release

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode = M_IDLE; m_lfsr = SEED; exp_q.delete();
      m_len = 0; m_t = 0; m_pos = 0; m_wait = 0; m_held = 1'b0;
    end else begin
      logic [7:0] pre;
      pre    = m_lfsr;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      case (m_mode)
        M_IDLE, M_WIN, M_LOSE: begin
          if (start) begin
            m_mode = M_PLAY; m_len = 1; m_t = 0; exp_q.delete();
          end
        end
        M_PLAY: begin
          // The first cycle of a round appends the new arrow; then each arrow takes SHOW+GAP.
          if (m_t == 0) exp_q.push_back(pre[1:0]);
          m_t++;
          if (m_t == 1 + m_len * (SHOW + GAP)) begin
            m_mode = M_INPUT; m_pos = 0; m_held = 1'b0; m_wait = 0;
          end
        end
        M_INPUT: begin
          if (!m_held) begin
            if (dir_in[2] == 1'b0) begin
              if (dir_in[1:0] == exp_q[m_pos]) m_held = 1'b1;
              else m_mode = M_LOSE;
            end else begin
              m_wait++;
`ifdef SIMON_TIMEOUT_EN
              if (m_wait == TMO) m_mode = M_LOSE;
`endif
            end
          end else if (dir_in[2] == 1'b1) begin
            if (m_pos + 1 < m_len) begin
              m_pos++; m_held = 1'b0; m_wait = 0;
            end else if (m_len == MAX_LEN) begin
              m_mode = M_WIN;
            end else begin
              m_mode = M_PLAY; m_len++; m_t = 0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] ea;
      int         es, ew, eg, el, u;
      ea = 3'b111; es = 0; ew = 0; eg = 0; el = 0; u = 0;
      case (m_mode)
        M_PLAY: begin
          if (m_t == 0) begin
            el = m_len - 1;
          end else begin
            el = m_len; es = 1; u = m_t - 1;
            if (u % (SHOW + GAP) < SHOW) ea = {1'b0, exp_q[u / (SHOW + GAP)]};
          end
        end
        M_INPUT: begin
          el = m_len;
          if (dir_in[2] == 1'b0) ea = dir_in;
        end
        M_WIN:  begin el = m_len; ew = 1; end
        M_LOSE: begin el = m_len; eg = 1; end
        default: ;
      endcase
      check("arrow_out",  int'(arrow_out),  int'(ea));
      check("show_phase", int'(show_phase), es);
      check("level",      int'(level),      el);
      check("win",        int'(win),        ew);
      check("game_over",  int'(game_over),  eg);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [2:0] rand_idle();
    logic [2:0] c;
    case ($urandom_range(0, 3))
      0: c = 3'b111;
      1: c = 3'b100;
      2: c = 3'b101;
      default: c = 3'b110;
    endcase
    return c;
  endfunction

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_input(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_mode == M_INPUT && !m_held) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check("wait_input_bound", 0, 1);
  endtask

  // Idle for a few random cycles, then press code for hold cycles and release.
  task automatic enter(input logic [2:0] code, input int hold);
    int pre_idle;
    pre_idle = $urandom_range(0, 3);
    for (int i = 0; i < pre_idle; i++) begin dir_in = rand_idle(); tick(); end
    dir_in = code;
    for (int i = 0; i < hold; i++) tick();
    dir_in = rand_idle();
    tick();
  endtask

  // Play one round. wrong_pos < 0 means every entry is correct.
  // long_pos gets a 10-cycle hold.
  task automatic play_level(input int wrong_pos, input int long_pos);
    bit ok;
    int len;
    logic [1:0] a;
    wait_input(ok);
    if (ok) begin
      len = m_len;
      for (int p = 0; p < len; p++) begin
        a = exp_q[p];
        if (p == wrong_pos) begin
          a = a ^ 2'($urandom_range(1, 3));
          dir_in = {1'b0, a};
          tick();
          check("lose_flag", int'(game_over), 1);
          check("lose_level", int'(level), len);
          dir_in = 3'b111;
          break;
        end
        enter({1'b0, a}, (p == long_pos) ? 10 : $urandom_range(1, 4));
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    resetn = 1'b0; start = 1'b0; dir_in = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_arrow", int'(arrow_out), 7);
    check("rst_level", int'(level), 0);
    check("rst_show",  int'(show_phase), 0);
    check("rst_win",   int'(win), 0);
    check("rst_over",  int'(game_over), 0);
    resetn = 1'b1;

    // First game: arrow after SEED A5 with start sampled on the 2nd edge is DOWN.
    tick();
    pulse_start();
    tick();
    check("first_arrow", int'(arrow_out), 3'b001);
    check("first_show",  int'(show_phase), 1);
    check("first_level", int'(level), 1);

    // Reset mid-SHOW aborts immediately.
    tick();
    resetn = 1'b0;
    #1;
    check("midrst_arrow", int'(arrow_out), 7);
    check("midrst_level", int'(level), 0);
    check("midrst_show",  int'(show_phase), 0);
    tick();
    resetn = 1'b1;
    repeat ($urandom_range(1, 5)) tick();

    // Game to WIN; a stray start during play must be ignored.
    pulse_start();
    repeat (3) tick();
    pulse_start();
    play_level(-1, -1);
    play_level(-1, 0);
    play_level(-1, -1);
    check("win_flag",  int'(win), 1);
    check("win_level", int'(level), 3);
    check("win_arrow", int'(arrow_out), 7);
    for (int i = 0; i < 20; i++) begin dir_in = 3'($urandom_range(0, 7)); tick(); end
    dir_in = 3'b111;
    tick();
    check("win_hold", int'(win), 1);

    // Game lost at level 2, position 1.
    pulse_start();
    check("restart_win", int'(win), 0);
    check("restart_lvl", int'(level), 0);
    play_level(-1, -1);
    play_level(1, -1);
    repeat (3) tick();
    check("lose_hold", int'(game_over), 1);
    pulse_start();
    check("restart_over", int'(game_over), 0);
    tick();
    check("restart_level1", int'(level), 1);

    // Invalid code 101 is no entry; then the idle-wait behaviour.
    wait_input(ok);
    dir_in = 3'b101;
    repeat (5) tick();
    check("code101_over",  int'(game_over), 0);
    check("code101_arrow", int'(arrow_out), 7);
    dir_in = 3'b111;
`ifdef SIMON_TIMEOUT_EN
    repeat (TMO + 2) tick();
    check("timeout_over", int'(game_over), 1);
`else
    repeat (1000) tick();
    check("notimeout_over",  int'(game_over), 0);
    check("notimeout_level", int'(level), 1);
    check("notimeout_show",  int'(show_phase), 0);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, dbg_state=%0d", dbg_state);
    $fatal(1);
  end

endmodule
